// File: rtl/fp_acc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fp_acc_unit (with tiny_nn_pkg and fp_add)
//  Description : Streaming bfloat16 vector accumulator. Elements arrive over
//                a valid/ready input; the element flagged last closes the
//                vector, and the sum plus element count is offered on a
//                valid/ready output. Addition uses one combinational fp_add.
//                Optional macro FP_ACC_RELU_EN clamps negative sums to +0 on
//                the output.
//  Revision    : 1.0 - initial release
// ============================================================================

package tiny_nn_pkg;
    typedef struct packed {
        logic       sgn;
        logic [7:0] exp;
        logic [6:0] mant;
    } fp_t;
endpackage

// ----------------------------------------------------------------------------
//  fp_add : combinational bfloat16 adder. Round-to-nearest-even, subnormal
//  operands/results flushed to zero, overflow to infinity, exact
//  cancellation gives +0.
// ----------------------------------------------------------------------------
module fp_add (
    input  tiny_nn_pkg::fp_t a_i,
    input  tiny_nn_pkg::fp_t b_i,
    output tiny_nn_pkg::fp_t sum_o
);
    tiny_nn_pkg::fp_t w_big;
    tiny_nn_pkg::fp_t w_small;
    logic [7:0]        w_diff;
    logic [3:0]        w_shamt;
    logic [10:0]       w_ma;
    logic [10:0]       w_mb;
    logic [21:0]       w_ext;
    logic [10:0]       w_aligned;
    logic [11:0]       w_sum;
    logic [3:0]        w_lz;
    logic [10:0]       w_norm;
    logic              w_up;
    logic [8:0]        w_rnd;
    logic signed [9:0] w_exp;

    // Align, add/subtract magnitudes, normalise, round and pack.
    always_comb begin
        // Order operands so that w_big has the larger magnitude.
        if ({a_i.exp, a_i.mant} >= {b_i.exp, b_i.mant}) begin
            w_big   = a_i;
            w_small = b_i;
        end else begin
            w_big   = b_i;
            w_small = a_i;
        end
        w_diff  = w_big.exp - w_small.exp;
        w_shamt = (w_diff > 8'd12) ? 4'd12 : w_diff[3:0];

        // Frame: hidden bit, 7 fraction bits, guard, round, sticky.
        w_ma = (w_big.exp == 8'd0)   ? 11'd0 : {1'b1, w_big.mant, 3'b000};
        w_mb = (w_small.exp == 8'd0) ? 11'd0 : {1'b1, w_small.mant, 3'b000};

        // Shifted-out bits of the smaller operand collapse into sticky.
        w_ext     = {w_mb, 11'd0} >> w_shamt;
        w_aligned = w_ext[21:11] | {10'd0, |w_ext[10:0]};

        if (w_big.sgn ^ w_small.sgn) begin
            w_sum = {1'b0, w_ma} - {1'b0, w_aligned};
        end else begin
            w_sum = {1'b0, w_ma} + {1'b0, w_aligned};
        end

        // Leading-zero count over the 11-bit frame; highest set bit wins.
        w_lz = 4'd11;
        for (int i = 0; i <= 10; i++) begin
            if (w_sum[i]) begin
                w_lz = 4'(10 - i);
            end
        end

        w_exp = $signed({2'b00, w_big.exp});
        if (w_sum[11]) begin
            w_norm = w_sum[11:1] | {10'd0, w_sum[0]};
            w_exp  = w_exp + 10'sd1;
        end else begin
            w_norm = w_sum[10:0] << w_lz;
            w_exp  = w_exp - $signed({6'd0, w_lz});
        end

        w_up  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd = {1'b0, w_norm[10:3]} + {8'd0, w_up};
        if (w_rnd[8]) begin
            w_exp = w_exp + 10'sd1;
        end

        sum_o.sgn  = w_big.sgn;
        sum_o.exp  = w_exp[7:0];
        sum_o.mant = w_rnd[8] ? w_rnd[7:1] : w_rnd[6:0];

        if (w_sum == 12'd0) begin
            sum_o = '0;
        end else if (w_exp > 10'sd254) begin
            sum_o = '{sgn: w_big.sgn, exp: 8'hFF, mant: 7'd0};
        end else if (w_exp < 10'sd1) begin
            sum_o = '{sgn: w_big.sgn, exp: 8'h00, mant: 7'd0};
        end

        // Infinity / NaN: the special operand always sorts as w_big.
        if (w_big.exp == 8'hFF) begin
            if (w_big.mant != 7'd0) begin
                sum_o = '{sgn: w_big.sgn, exp: 8'hFF, mant: w_big.mant | 7'h40};
            end else if ((w_small.exp == 8'hFF) && (w_big.sgn ^ w_small.sgn)) begin
                sum_o = '{sgn: 1'b0, exp: 8'hFF, mant: 7'h40};
            end else begin
                sum_o = w_big;
            end
        end
    end
endmodule

// ----------------------------------------------------------------------------
//  fp_acc_unit : accumulator FSM around a single fp_add instance.
// ----------------------------------------------------------------------------
module fp_acc_unit #(
    parameter int CountW = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  tiny_nn_pkg::fp_t    in_op_i,
    input  logic                in_last_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output tiny_nn_pkg::fp_t    out_result_o,
    output logic [CountW-1:0]   out_count_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    tiny_nn_pkg::fp_t    r_acc;
    tiny_nn_pkg::fp_t    w_sum;
    logic [CountW-1:0]   r_count;
    logic                w_accept;
    logic                w_load_first;
    logic                w_load_add;

    fp_add u_fp_add (
        .a_i   (r_acc),
        .b_i   (in_op_i),
        .sum_o (w_sum)
    );

    // State register; reset abandons any partial or pending vector.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_next = r_state;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        w_load_first = 1'b0;
        w_load_add   = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready_o   = 1'b1;
                w_accept     = in_valid_i;
                w_load_first = in_valid_i;
                if (in_valid_i) begin
                    w_state_next = in_last_i ? OUT : ACC;
                end
            end
            ACC: begin
                in_ready_o = 1'b1;
                w_accept   = in_valid_i;
                w_load_add = in_valid_i;
                if (in_valid_i && in_last_i) begin
                    w_state_next = OUT;
                end
            end
            OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Accumulator and saturating element counter, updated only on accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            if (w_load_first) begin
                r_acc   <= in_op_i;
                r_count <= CountW'(1);
            end else if (w_load_add) begin
                r_acc <= w_sum;
                if (r_count != {CountW{1'b1}}) begin
                    r_count <= r_count + CountW'(1);
                end
            end
        end
    end

`ifdef FP_ACC_RELU_EN
    // Negative sums are clamped to +0 on the way out; accumulator untouched.
    assign out_result_o = r_acc.sgn ? tiny_nn_pkg::fp_t'(16'h0000) : r_acc;
`else
    assign out_result_o = r_acc;
`endif
    assign out_count_o  = r_count;
endmodule

`default_nettype wire

// File: tb/tb_fp_acc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_acc_unit
//  Description : Directed self-checking bench for fp_acc_unit; a second
//                instance with CountW=2 shares the stimulus to show count
//                saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_acc_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_op;
    logic        in_last;
    logic        out_ready;
    logic        in_ready,  in_ready2;
    logic        out_valid, out_valid2;
    logic [15:0] out_result, out_result2;
    logic [7:0]  out_count;
    logic [1:0]  out_count2;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    fp_acc_unit #(.CountW(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_op_i(in_op), .in_last_i(in_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_result_o(out_result), .out_count_o(out_count)
    );

    fp_acc_unit #(.CountW(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .in_op_i(in_op), .in_last_i(in_last),
        .out_valid_o(out_valid2), .out_ready_i(out_ready),
        .out_result_o(out_result2), .out_count_o(out_count2)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One accepted element; afterwards idle inputs carry junk that must be ignored.
    task automatic send(input logic [15:0] op, input logic last);
        check("send_in_ready", {15'd0, in_ready}, 16'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 16'hDEAD;
        in_last  = 1'b1;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] res, input int cnt);
        int cnt2;
        cnt2 = (cnt > 3) ? 3 : cnt;
        check({tag, "_valid"},  {15'd0, out_valid},  16'd1);
        check({tag, "_result"}, out_result,          res);
        check({tag, "_count"},  {8'd0, out_count},   16'(cnt));
        check({tag, "_valid2"}, {15'd0, out_valid2}, 16'd1);
        check({tag, "_count2"}, {14'd0, out_count2}, 16'(cnt2));
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("take_valid_low", {15'd0, out_valid}, 16'd0);
        check("take_in_ready",  {15'd0, in_ready},  16'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 16'h0000;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {15'd0, in_ready},  16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_result",    out_result,         16'h0000);
        check("rst_count",     {8'd0, out_count},  16'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1.0 + 1.0
        send(16'h3F80, 1'b0);
        check("t1_mid_valid", {15'd0, out_valid}, 16'd0);
        send(16'h3F80, 1'b1);
        expect_out("t1", 16'h4000, 2);
        take();

        // 1.0 + 0.5 + 0.5, then single 1.5
        send(16'h3F80, 1'b0);
        send(16'h3F00, 1'b0);
        send(16'h3F00, 1'b1);
        expect_out("t2", 16'h4000, 3);
        take();
        send(16'h3FC0, 1'b1);
        expect_out("t2_single", 16'h3FC0, 1);
        take();

        // 0.5 + -1.0 = -0.5 (clamped when ReLU enabled)
        send(16'h3F00, 1'b0);
        send(16'hBF80, 1'b1);
`ifdef FP_ACC_RELU_EN
        expect_out("t3_relu", 16'h0000, 2);
`else
        expect_out("t3", 16'hBF00, 2);
`endif
        take();

        // Exact cancellation 2.0 + -2.0 = +0
        send(16'h4000, 1'b0);
        send(16'hC000, 1'b1);
        expect_out("t4_cancel", 16'h0000, 2);
        take();

        // Output stall with input pulses that must not be accepted
        send(16'h3F80, 1'b1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_op    = 16'h4000;
            in_last  = 1'b1;
            expect_out("t5_stall", 16'h3F80, 1);
            check("t5_in_ready_low", {15'd0, in_ready}, 16'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        take();
        @(posedge clk);
        #1;
        check("t5_no_extra_out", {15'd0, out_valid}, 16'd0);

        // Reset mid-vector discards the partial sum
        send(16'h4000, 1'b0);
        send(16'h4000, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid",  {15'd0, out_valid}, 16'd0);
        check("t6_rst_result", out_result,         16'h0000);
        check("t6_rst_count",  {8'd0, out_count},  16'd0);
        check("t6_rst_ready",  {15'd0, in_ready},  16'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t6_post_valid", {15'd0, out_valid}, 16'd0);
        send(16'h3F80, 1'b1);
        expect_out("t6", 16'h3F80, 1);
        take();

        // Five 1.0 elements: sum 5.0, narrow counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            send(16'h3F80, (k == 4) ? 1'b1 : 1'b0);
        end
        expect_out("t7_sat", 16'h40A0, 5);
        check("t7_result2", out_result2, 16'h40A0);
        take();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/fp_acc_unit.md
FP_ACC_UNIT -- requirements
Module: fp_acc_unit

Interface
REQ-001 SHALL have parameter: CountW, 8, width of the element-count output.
REQ-002 SHALL have port: clk_i  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid_i  input  1  operand offered.
REQ-005 SHALL have port: in_ready_o  output  1  operand accepted when high with in_valid_i.
REQ-006 SHALL have port: in_op_i  input  fp_t (16)  bfloat16 operand, tiny_nn_pkg fp_t {sgn, exp[7:0], mant[6:0]}.
REQ-007 SHALL have port: in_last_i  input  1  marks final element of the current vector.
REQ-008 SHALL have port: out_valid_o  output  1  accumulated result available.
REQ-009 SHALL have port: out_ready_i  input  1  consumer takes result when high with out_valid_o.
REQ-010 SHALL have port: out_result_o  output  fp_t (16)  accumulated sum.
REQ-011 SHALL have port: out_count_o  output  CountW  number of elements summed into out_result_o.

Function
REQ-012 SHALL implement FSM states IDLE, ACC, OUT.
REQ-013 SHALL drive in_ready_o high in IDLE and ACC and low in OUT.
REQ-014 SHALL, on accept in IDLE, load the accumulator with in_op_i unmodified, set count to 1, and go to ACC (or to OUT if in_last_i).
REQ-015 SHALL, on accept in ACC, load the accumulator with fp_add(accumulator, in_op_i) via one instance of the existing combinational fp_add, increment count, and stay in ACC (or go to OUT if in_last_i).
REQ-016 SHALL take its rounding, overflow and cancellation semantics solely from fp_add; this block adds no arithmetic.
REQ-017 SHALL hold count at 2^CountW-1 once reached (saturate, no wrap); accumulation still continues.
REQ-018 SHALL assert out_valid_o in OUT only, first in the cycle after the last element is accepted (latency 1 cycle from the last-element handshake).
REQ-019 SHALL hold out_result_o and out_count_o stable while out_valid_o is high and out_ready_i is low.
REQ-020 SHALL, on the out handshake, go to IDLE; in_ready_o rises in the following cycle (no same-cycle input accept in OUT).
REQ-021 SHALL ignore in_op_i and in_last_i whenever no input handshake occurs.
REQ-022 SHALL, for a single-element vector (in_last_i on first accept), output that operand bit-exact with count 1.
REQ-023 SHALL drive out_result_o and out_count_o from registers only, with no combinational path from any input.

Reset
REQ-024 SHALL, while rst_ni is low, force state IDLE, accumulator 16'h0000, count 0, out_valid_o 0, and in_ready_o 1.
REQ-025 SHALL, on reset assertion mid-vector or during OUT, discard partial or pending results with no output handshake.

Configuration
REQ-026 SHALL support macro FP_ACC_RELU_EN: when defined, out_result_o is +0 (16'h0000) whenever the accumulated sign bit is 1, and the accumulator is otherwise unchanged.
REQ-027 SHALL, when FP_ACC_RELU_EN is undefined, present the signed accumulator value unmodified.

Verification
REQ-028 SHALL cover: 3F80, 3F80(last) -> one cycle later out_valid_o=1, out_result_o=4000, out_count_o=2.
REQ-029 SHALL cover: 3F80, 3F00, 3F00(last) -> 4000, count 3; then 3FC0(last) alone -> 3FC0, count 1.
REQ-030 SHALL cover: 3F00, BF80(last) -> BF00 without FP_ACC_RELU_EN and 0000 with it; count 2 in both builds.
REQ-031 SHALL cover: 3F80(last) with out_ready_i held low 5 cycles -> out_valid_o, 3F80 and count 1 stable; in_ready_o low throughout; in_valid_i pulses are not accepted; in_ready_o is high the cycle after the handshake.
REQ-032 SHALL cover: 4000, 4000, then rst_ni low for 1 cycle, then 3F80(last) -> 3F80, count 1, with no output between reset and that result.
REQ-033 SHALL cover, with CountW=2: five 3F80 elements (last on the fifth) -> count saturates at 3 and result is 40A0.
